// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl
// Multi-cycle sequencer for the MIPS-32 datapath. It steps each instruction
// through fetch / decode / execute / memory / writeback, stalls on the
// shared memory port via mem_ready, and counts retired instructions.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   opcode[5:0]       IR[31:26], valid from DECODE onward
//   zero              ALU zero flag (used in BEQ only)
//   mem_ready         memory completes current access this cycle
//   PCWrite .. PCSource  datapath mux selects / enables
//   illegal           one-cycle pulse in DECODE for an unsupported opcode
//   state[3:0]        current state (debug)
//   retired[CNT_W-1:0] retired-instruction count, wraps
//
// Build option: MIPS_CTRL_JUMP_EN enables the j instruction (opcode 000010).
// Without it, 000010 decodes as illegal and the JUMP state is unreachable.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] retired
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_REXEC  = 4'd6,
    S_RWB    = 4'd7,
    S_BEQ    = 4'd8,
    S_JUMP   = 4'd9
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t cur, nxt;
  logic   op_known;
  logic   retire;

  // Opcodes the sequencer can handle; everything else pulses illegal.
  always_comb begin
    op_known = (opcode == OP_RTYPE) || (opcode == OP_LW) ||
               (opcode == OP_SW)    || (opcode == OP_BEQ);
`ifdef MIPS_CTRL_JUMP_EN
    op_known = op_known || (opcode == OP_J);
`endif
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = cur;
    case (cur)
      S_FETCH:  if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        nxt = S_FETCH;
        if (opcode == OP_RTYPE)                        nxt = S_REXEC;
        else if (opcode == OP_LW || opcode == OP_SW)   nxt = S_MEMADR;
        else if (opcode == OP_BEQ)                     nxt = S_BEQ;
`ifdef MIPS_CTRL_JUMP_EN
        else if (opcode == OP_J)                       nxt = S_JUMP;
`endif
      end
      // Only lw/sw reach MEMADR; anything not sw is treated as the load.
      S_MEMADR: nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (mem_ready) nxt = S_MEMWB;
      S_MEMWR:  if (mem_ready) nxt = S_FETCH;
      S_REXEC:  nxt = S_RWB;
      default:  nxt = S_FETCH; // MEMWB, RWB, BEQ, JUMP and unused codes
    endcase
  end

  // Output logic; everything is held low while reset is asserted so no
  // strobe or register write escapes in the reset cycle.
  always_comb begin
    PCWrite  = 1'b0;
    IorD     = 1'b0;
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    IRWrite  = 1'b0;
    RegDst   = 1'b0;
    MemtoReg = 1'b0;
    RegWrite = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    ALUOp    = 2'b00;
    PCSource = 2'b00;
    illegal  = 1'b0;
    if (!reset) begin
      case (cur)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready; // PC+4 and IR load only when the read lands
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;     // precompute branch target into ALUOut
          illegal = !op_known;
        end
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEMRD: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWR: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_REXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_RWB: begin
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BEQ: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b01;
          PCSource = 2'b01;
          PCWrite  = zero;
        end
`ifdef MIPS_CTRL_JUMP_EN
        S_JUMP: begin
          PCSource = 2'b10;
          PCWrite  = 1'b1;
        end
`endif
        default: ;
      endcase
    end
  end

  // An instruction retires in its final cycle; memory-write finishes only
  // when the port accepts it.
  always_comb begin
    retire = (cur == S_MEMWB) || (cur == S_RWB) || (cur == S_BEQ) ||
             (cur == S_JUMP)  || ((cur == S_MEMWR) && mem_ready);
  end

  always_ff @(posedge clk) begin
    if (reset)       retired <= '0;
    else if (retire) retired <= retired + 1'b1;
  end

  assign state = cur;

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle sequencer for the MIPS-32 datapath. It replaces the single-cycle opcode decoder with a Moore/Mealy state machine that steps each instruction through fetch, decode, execute, memory and writeback. It stalls on a shared memory port via a ready handshake and counts retired instructions. It sits between the instruction register (opcode source), the ALU zero flag, the unified memory and the datapath muxes and enables.

## Interface

Parameters:
- CNT_W, 32, width of retired-instruction counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- opcode  in  6  instruction[31:26] from IR; valid from DECODE onward
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes current read/write this cycle
- PCWrite  out  1  PC load enable (branch condition already resolved)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemRead, MemWrite  out  1 each  memory strobes
- IRWrite  out  1  instruction register load
- RegDst, MemtoReg, RegWrite  out  1 each  register file controls
- ALUSrcA  out  1  0 = PC, 1 = rs
- ALUSrcB  out  2  00 = rt, 01 = 4, 10 = sign-ext imm, 11 = sign-ext imm << 2
- ALUOp  out  2  00 add, 01 sub, 10 funct-decoded
- PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target
- illegal  out  1  one-cycle pulse: unsupported opcode
- state  out  4  current state, for debug
- retired  out  CNT_W  retired-instruction count

## Operation

- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, REXEC=6, RWB=7, BEQ=8, JUMP=9.
- Any control output not listed for a state is 0.
- **FETCH:** IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - IRWrite and PCWrite equal mem_ready (Mealy).
  - mem_ready=1 → DECODE; otherwise hold.
- **DECODE:** ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
  - 000000 → REXEC
  - 100011 or 101011 → MEMADR
  - 000100 → BEQ
  - 000010 → JUMP (only when the macro is enabled)
  - any other opcode → FETCH, with illegal=1 for this cycle
- **MEMADR:** ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD; sw → MEMWR.
- **MEMRD:** IorD=1, MemRead=1. Hold until mem_ready=1, then → MEMWB.
- **MEMWB:** RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- **MEMWR:** IorD=1, MemWrite=1. Hold until mem_ready=1, then → FETCH.
- **REXEC:** ALUSrcA=1, ALUSrcB=00, ALUOp=10 → RWB.
- **RWB:** RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- **BEQ:** ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, PCWrite=zero → FETCH.
- **JUMP:** PCSource=10, PCWrite=1 → FETCH.
- **retired:**
  - increments by 1 on the last cycle of: MEMWB, MEMWR (with mem_ready=1), RWB, BEQ, JUMP
  - wraps modulo 2^CNT_W
  - illegal opcodes do not retire

## Timing

- Reset (reset=1 at a rising edge): state←FETCH, retired←0.
  - While reset=1, every control output and illegal are forced to 0, so no memory strobe is issued during reset.
  - state and retired show their post-reset values from the cycle after the sampled edge.
- Reset mid-instruction: abandons it. No RegWrite or MemWrite issues in the reset cycle, and retired does not count the instruction.
- Latency with mem_ready held at 1:
  - R-type 4 cycles
  - lw 5
  - sw 4
  - beq 3
  - j 3
  - illegal 2
- Each cycle of mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. Outputs stay constant while stalled.
- mem_ready is ignored in all other states.
- opcode must be stable from DECODE through the instruction's final state; IR is only written in FETCH.
- zero is sampled combinationally in the BEQ cycle only.

## Configuration

- MIPS_CTRL_JUMP_EN defined:
  - opcode 000010 → JUMP
  - illegal is not asserted for it
  - it retires
- Undefined:
  - JUMP is unreachable
  - 000010 is treated as illegal: DECODE → FETCH, illegal pulse, no retire
  - PCSource=10 is never driven

## Test plan

- Reset asserted 3 cycles, mem_ready=1 → all controls 0 during reset; next cycle state=0, MemRead=1, IorD=0, IRWrite=1, PCWrite=1; retired=0.
- R-type (opcode 000000), mem_ready=1 → states 0,1,6,7,0; RWB cycle has RegDst=1, RegWrite=1; retired=1 after 4 cycles.
- lw with mem_ready low 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; MemRead and IorD stable during stall; RegWrite=1, MemtoReg=1 in MEMWB; 7 cycles total.
- beq with zero=1, then beq with zero=0 → BEQ cycle PCWrite=1/0 respectively, PCSource=01, ALUOp=01; retired +2.
- Opcode 000010 → with the macro: state 9, PCWrite=1, PCSource=10, retired +1. Without the macro: illegal=1 in DECODE, back to FETCH, retired unchanged.
- retired preloaded to 2^CNT_W−1 by forcing, then one sw → retired=0; reset asserted in MEMWR → no MemWrite, state=FETCH next.
